// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit data-memory controller:
// access-size encodings and the controller FSM state type.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_STORE,
    S_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane extract + sign/zero extend for loads, lane merge for sub-word stores.
// Ports: word_i (DMEM word), lane_i (addr[1:0]), size_i, uns_i, wdata_i;
//        ld_data_o (extended load value), st_word_o (merged store word).
module lsu_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] word_i,
  input  logic [1:0]   lane_i,
  input  logic [1:0]   size_i,
  input  logic         uns_i,
  input  logic [N-1:0] wdata_i,
  output logic [N-1:0] ld_data_o,
  output logic [N-1:0] st_word_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = word_i[8*lane_i +: 8];
    half_v    = word_i[16*lane_i[1] +: 16];
    ld_data_o = word_i;
    st_word_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{(N-8){~uns_i & byte_v[7]}}, byte_v};
        st_word_o = word_i;
        st_word_o[8*lane_i +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        ld_data_o = {{(N-16){~uns_i & half_v[15]}}, half_v};
        st_word_o = word_i;
        st_word_o[16*lane_i[1] +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Single-outstanding LSU controller in front of a combinational-read DMEM.
// CPU side: req_* valid/ready request, resp_* valid/ready response.
// DMEM side: dmem_addr_o word address, dmem_st_en_o/dmem_st_data_o write,
// dmem_ld_data_i read data. Sub-word stores do read-modify-write.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int N       = 32,
  parameter int ADDRESS = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_unsigned_i,
  input  logic [31:0]        req_addr_i,
  input  logic [N-1:0]       req_wdata_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [N-1:0]       resp_rdata_o,
  output logic               resp_err_o,
  output logic [ADDRESS-1:0] dmem_addr_o,
  output logic [N-1:0]       dmem_st_data_o,
  output logic               dmem_st_en_o,
  input  logic [N-1:0]       dmem_ld_data_i
);

  lsu_state_e state_q, state_d;

  logic               we_q;
  logic               uns_q;
  logic [1:0]         size_q;
  logic [1:0]         lane_q;
  logic [ADDRESS-1:0] waddr_q;
  logic [N-1:0]       st_data_q;
  logic [N-1:0]       rdata_q;
  logic               err_q;

  logic               accept;
  logic               req_err;
  logic [N-1:0]       ld_ext;
  logic [N-1:0]       st_merge;

  assign accept = req_valid_i & (state_q == S_IDLE);

  always_comb begin
    req_err = (req_size_i == 2'b11)
            | ((req_size_i == SZ_HALF) & req_addr_i[0])
            | ((req_size_i == SZ_WORD) & (|req_addr_i[1:0]))
            | (|req_addr_i[31:ADDRESS+2]);
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    dmem_st_en_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (req_err)
            state_d = S_RESP;
          else if (!req_we_i)
            state_d = S_LOAD;
          else if (req_size_i == SZ_WORD)
            state_d = S_STORE;
          else
            state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_STORE;
      S_STORE: begin
        dmem_st_en_o = we_q;
        state_d      = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // st_data_q holds wdata until RMW_RD overwrites it with the merged word,
  // so it also serves as the merge source.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= SZ_BYTE;
      lane_q    <= 2'b00;
      waddr_q   <= '0;
      st_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        we_q      <= req_we_i;
        uns_q     <= req_unsigned_i;
        size_q    <= req_size_i;
        lane_q    <= req_addr_i[1:0];
        waddr_q   <= req_addr_i[ADDRESS+1:2];
        st_data_q <= req_wdata_i;
        rdata_q   <= '0;
        err_q     <= req_err;
      end
      if (state_q == S_LOAD)
        rdata_q <= ld_ext;
      if (state_q == S_RMW_RD)
        st_data_q <= st_merge;
    end
  end

  lsu_align #(.N(N)) u_align (
    .word_i    (dmem_ld_data_i),
    .lane_i    (lane_q),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .wdata_i   (st_data_q),
    .ld_data_o (ld_ext),
    .st_word_o (st_merge)
  );

  assign dmem_addr_o    = waddr_q;
  assign dmem_st_data_o = st_data_q;
  assign resp_rdata_o   = rdata_q;
  assign resp_err_o     = err_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl: byte-array reference model,
// directed cases plus randomized loads/stores, decoupled response monitor.
module tb_lsu_dmem_ctrl;

  localparam int N    = 32;
  localparam int AW   = 10;
  localparam int MEMB = 4 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [1:0]    req_size_i = 2'b00;
  logic          req_unsigned_i = 1'b0;
  logic [31:0]   req_addr_i = '0;
  logic [N-1:0]  req_wdata_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic [N-1:0]  resp_rdata_o;
  logic          resp_err_o;
  logic [AW-1:0] dmem_addr_o;
  logic [N-1:0]  dmem_st_data_o;
  logic          dmem_st_en_o;
  logic [N-1:0]  dmem_ld_data_i;

  always #5 clk_i = ~clk_i;

  lsu_dmem_ctrl #(.N(N), .ADDRESS(AW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_st_data_o (dmem_st_data_o),
    .dmem_st_en_o   (dmem_st_en_o),
    .dmem_ld_data_i (dmem_ld_data_i)
  );

  logic [31:0] dmem [0:(1<<AW)-1];
  assign dmem_ld_data_i = dmem[dmem_addr_o];
  always @(posedge clk_i)
    if (dmem_st_en_o) dmem[dmem_addr_o] <= dmem_st_data_o;

  logic [7:0] refb [0:MEMB-1];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          st_at;
  } exp_t;

  exp_t sbq[$];
  int tests = 0, fails = 0, cyc = 0;
  int st_cnt = 0, exp_st = 0;
  bit stall_mode = 1'b0;
  bit in_resp = 1'b0;
  logic [31:0] last_rd;
  logic        last_err;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) begin
    #1;
    resp_ready_i = stall_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (dmem_st_en_o) begin
        st_cnt++;
        if (sbq.size() == 0) chk("st_en_unexpected", 1, 0);
        else chk("st_en_cycle", cyc - sbq[0].acc, sbq[0].st_at);
      end
      if (resp_valid_o) begin
        chk("req_ready_in_resp", {31'b0, req_ready_o}, 0);
        if (!in_resp) begin
          if (sbq.size() == 0) chk("resp_unexpected", 1, 0);
          else begin
            chk("rdata", resp_rdata_o, sbq[0].rdata);
            chk("err", {31'b0, resp_err_o}, {31'b0, sbq[0].err});
            chk("latency", cyc - sbq[0].acc, sbq[0].lat);
          end
          in_resp  = 1'b1;
          last_rd  = resp_rdata_o;
          last_err = resp_err_o;
        end else begin
          chk("rdata_stable", resp_rdata_o, last_rd);
          chk("err_stable", {31'b0, resp_err_o}, {31'b0, last_err});
        end
        if (resp_ready_i) begin
          if (sbq.size() != 0) void'(sbq.pop_front());
          in_resp = 1'b0;
        end
      end
    end
  end

  task automatic issue(bit we, logic [1:0] sz, bit uns,
                       logic [31:0] a, logic [31:0] wd, bit track);
    exp_t e;
    int n = 0;
    int nb;
    logic [63:0] v;
    bit err;
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 2'b00) || (a >= MEMB);
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = a;
    req_wdata_i    = wd;
    e.acc   = cyc;
    e.rdata = '0;
    e.err   = err;
    e.st_at = -1;
    e.lat   = 1;
    if (!err) begin
      nb = 1 << sz;
      if (!we) begin
        v = '0;
        for (int i = 0; i < nb; i++)
          v |= 64'(refb[a + i]) << (8 * i);
        if (!uns && v[8*nb-1])
          v |= ~((64'd1 << (8 * nb)) - 64'd1);
        e.rdata = v[31:0];
        e.lat   = 2;
      end else if (track) begin
        for (int i = 0; i < nb; i++)
          refb[a + i] = wd[8*i +: 8];
        e.lat   = (sz == 2'b10) ? 2 : 3;
        e.st_at = (sz == 2'b10) ? 1 : 2;
        exp_st++;
      end
    end
    if (track) sbq.push_back(e);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !req_ready_o) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready_o}, 1);
    chk({tag, "_resp_valid"}, {31'b0, resp_valid_o}, 0);
    chk({tag, "_resp_err"}, {31'b0, resp_err_o}, 0);
    chk({tag, "_resp_rdata"}, resp_rdata_o, 0);
    chk({tag, "_st_en"}, {31'b0, dmem_st_en_o}, 0);
    chk({tag, "_dmem_addr"}, {22'b0, dmem_addr_o}, 0);
    chk({tag, "_st_data"}, dmem_st_data_o, 0);
  endtask

  initial begin
    int bad;
    int st_before;
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) dmem[i] = '0;
    for (int i = 0; i < MEMB; i++) refb[i] = '0;
    #2;
    chk_reset_outs("reset");
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1);
    issue(1, 2'b00, 0, 32'h11, 32'h0000007F, 1);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1);
    issue(1, 2'b10, 0, 32'h10, 32'h80FFFFFF, 1);
    issue(0, 2'b00, 0, 32'h13, 32'h0, 1);
    issue(0, 2'b00, 1, 32'h13, 32'h0, 1);
    issue(0, 2'b01, 0, 32'h12, 32'h0, 1);
    issue(0, 2'b01, 0, 32'h01, 32'h0, 1);
    issue(0, 2'b10, 0, 32'h1000, 32'h0, 1);
    issue(1, 2'b11, 0, 32'h20, 32'h12345678, 1);
    issue(1, 2'b01, 0, 32'h22, 32'hABCD, 1);
    issue(1, 2'b10, 0, 32'h1002, 32'h1, 1);
    drain();

    stall_mode = 1'b1;
    issue(0, 2'b10, 0, 32'h10, 32'h0, 1);
    begin
      int n = 0;
      while (!resp_valid_o && n < 20) begin
        @(negedge clk_i);
        n++;
      end
      chk("stall_resp_seen", {31'b0, resp_valid_o}, 1);
    end
    repeat (3) @(negedge clk_i);
    stall_mode = 1'b0;
    drain();

    st_before = st_cnt;
    issue(1, 2'b00, 0, 32'h21, 32'h55, 0);
    chk("abort_in_rmw", {29'b0, dut.state_q}, {29'b0, lsu_pkg::S_RMW_RD});
    #1 rst_i = 1'b1;
    #1 chk_reset_outs("abort");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("abort_no_write", st_cnt, st_before);
    chk("abort_no_resp", {31'b0, resp_valid_o}, 0);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = $urandom_range(0, 63);
      issue($urandom_range(0, 1), 2'($urandom_range(0, 3)),
            $urandom_range(0, 1), a, $urandom, 1);
    end
    drain();

    chk("st_en_total", st_cnt, exp_st);
    bad = 0;
    for (int w = 0; w < (1 << AW); w++)
      if (dmem[w] !== {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]})
        bad++;
    chk("mem_words_mismatching", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
LSU_DMEM_CTRL -- requirements
Module: lsu_dmem_ctrl

Interface
REQ-001 SHALL have parameter N, default 32: data width; only 32 is supported.
REQ-002 SHALL have parameter ADDRESS, default 10: DMEM word-address width (8..11).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid_i, input, 1 bit: CPU request valid.
REQ-006 SHALL have port req_ready_o, output, 1 bit: request accepted when high together with req_valid_i.
REQ-007 SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size_i, input, 2 bits: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-009 SHALL have port req_unsigned_i, input, 1 bit: load zero-extend when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata_i, input, N bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid_o, output, 1 bit: response valid.
REQ-013 SHALL have port resp_ready_i, input, 1 bit: CPU accepts the response.
REQ-014 SHALL have port resp_rdata_o, output, N bits: load result; 0 for stores and errors.
REQ-015 SHALL have port resp_err_o, output, 1 bit: misaligned, out-of-range or illegal-size request.
REQ-016 SHALL have port dmem_addr_o, output, ADDRESS bits: DMEM word address.
REQ-017 SHALL have port dmem_st_data_o, output, N bits: DMEM store word.
REQ-018 SHALL have port dmem_st_en_o, output, 1 bit: DMEM write enable; DMEM writes at the next rising edge.
REQ-019 SHALL have port dmem_ld_data_i, input, N bits: DMEM combinational read data for dmem_addr_o.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, RMW_RD, STORE, RESP; req_ready_o = 1 only in IDLE.
REQ-021 On acceptance in IDLE, SHALL latch we, size, unsigned, addr and wdata; word address = addr[ADDRESS+1:2].
REQ-022 SHALL flag an error if any of these holds: size = 11; half with addr[0] = 1; word with addr[1:0] != 0; addr[31:ADDRESS+2] != 0.
REQ-023 On error: IDLE->RESP with err = 1, no DMEM write; resp_valid_o is high in the cycle after acceptance.
REQ-024 Load: IDLE->LOAD->RESP; in LOAD, SHALL register the extracted/extended lane of dmem_ld_data_i; resp_valid_o is high 2 cycles after acceptance.
REQ-025 Word store: IDLE->STORE->RESP; in STORE, dmem_st_en_o = 1 and dmem_st_data_o = wdata.
REQ-026 Sub-word store: IDLE->RMW_RD->STORE->RESP; in RMW_RD, SHALL register dmem_ld_data_i with the addressed byte/half lane replaced by wdata[7:0]/[15:0]; STORE writes the merged word.
REQ-027 Byte lane = addr[1:0]; half lane = addr[1]; little-endian ordering.
REQ-028 dmem_st_en_o SHALL be 1 only in STORE, for exactly one cycle per store.
REQ-029 dmem_addr_o SHALL hold the latched word address in all states; resp_rdata_o/resp_err_o SHALL be stable while resp_valid_o = 1.
REQ-030 RESP SHALL hold resp_valid_o until resp_ready_i = 1, then go to IDLE; a new request is accepted no earlier than the following cycle.

Reset
REQ-031 rst_i SHALL immediately force IDLE, req_ready_o = 1, resp_valid_o = 0, resp_err_o = 0, resp_rdata_o = 0, dmem_st_en_o = 0, dmem_addr_o = 0, dmem_st_data_o = 0.
REQ-032 Reset during RMW_RD or STORE SHALL abort the access with no DMEM write and no response.

Structure
REQ-033 Shared package lsu_pkg SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state enum.
REQ-034 Lane extract/sign-extend and store merge SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-035 Store word 0xDEADBEEF at address 0x10, then load word at 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid_o 2 cycles after acceptance.
REQ-036 Store byte 0x7F at 0x11 over 0xDEADBEEF -> memory word 0xDEAD7FEF; st_en high exactly once, in cycle 2.
REQ-037 Load byte at 0x13 of 0x80FFFFFF: signed -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-038 Load half at 0x01; load word at 0x1000 (ADDRESS = 10) -> err 1, rdata 0, no st_en, response in the cycle after acceptance.
REQ-039 Hold resp_ready_i = 0 for 3 cycles -> resp_valid_o and data stay stable and req_ready_o stays 0.
REQ-040 Assert rst_i in RMW_RD -> no DMEM write, all outputs at reset values immediately.
